// File: rtl/frac_clk_div.sv
// rtl/frac_clk_div.sv - runtime-programmable dual-modulus fractional clock divider
//
// Average output period is N + NUM/DEN clk cycles. Each output period is N or
// N+1 cycles, chosen by a fractional accumulator. Duty is 50%: odd-length
// periods stretch the high phase by half a cycle using a negedge register.
//
// Ports:
//   clk           input clock
//   rst_n         asynchronous active-low reset
//   en            run enable (registered once internally)
//   cfg_int       requested integer divisor N (CNT_W bits)
//   cfg_num       requested numerator (FRAC_W bits)
//   cfg_den       requested denominator (FRAC_W bits)
//   cfg_load      one-cycle pulse, samples cfg_int/cfg_num/cfg_den
//   div_clk       divided clock
//   period_start  one-cycle pulse in the first clk cycle of each output period
//   cur_period    length of the period in progress (N or N+1, CNT_W+1 bits)
//   cfg_err       sticky: the last cfg_load was rejected

module frac_clk_div #(
  parameter int CNT_W   = 8,
  parameter int FRAC_W  = 8,
  parameter int INT_DEF = 8,
  parameter int NUM_DEF = 7,
  parameter int DEN_DEF = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [CNT_W-1:0]  cfg_int,
  input  logic [FRAC_W-1:0] cfg_num,
  input  logic [FRAC_W-1:0] cfg_den,
  input  logic              cfg_load,
  output logic              div_clk,
  output logic              period_start,
  output logic [CNT_W:0]    cur_period,
  output logic              cfg_err
);

  logic              en_q;
  logic              running;
  logic [CNT_W-1:0]  cnt;
  logic [FRAC_W:0]   acc;
  logic              odd;
  logic              r_p;
  logic              r_n;

  logic [CNT_W-1:0]  act_int;
  logic [FRAC_W-1:0] act_num;
  logic [FRAC_W-1:0] act_den;

  logic              pend_vld;
  logic [CNT_W-1:0]  pend_int;
  logic [FRAC_W-1:0] pend_num;
  logic [FRAC_W-1:0] pend_den;

  logic              cfg_ok;
  logic              period_end;
  logic              boundary;
  logic              go_idle;
  logic [CNT_W-1:0]  eff_int;
  logic [FRAC_W-1:0] eff_num;
  logic [FRAC_W-1:0] eff_den;
  logic [FRAC_W:0]   eff_acc;
  logic [FRAC_W:0]   sum;
  logic              carry;
  logic [FRAC_W:0]   acc_next;
  logic [CNT_W:0]    p_next;
  logic [CNT_W-1:0]  cnt_next;
  logic [CNT_W:0]    half_next;
  logic              r_p_next;

  always_comb begin
    cfg_ok     = cfg_load && (cfg_int >= CNT_W'(2)) && (cfg_den != '0) && (cfg_num < cfg_den);
    period_end = running && ({1'b0, cnt} == (cur_period - 1'b1));
    // A new period starts on the last count of a running period or on the
    // first cycle the registered enable is seen while idle.
    boundary   = en_q && (!running || period_end);
    go_idle    = period_end && !en_q;

    // A pending config takes effect at this boundary with a fresh accumulator.
    eff_int  = pend_vld ? pend_int : act_int;
    eff_num  = pend_vld ? pend_num : act_num;
    eff_den  = pend_vld ? pend_den : act_den;
    eff_acc  = pend_vld ? '0 : acc;

    // acc < DEN and NUM < DEN, so the sum fits in FRAC_W+1 bits.
    sum      = eff_acc + {1'b0, eff_num};
    carry    = (sum >= {1'b0, eff_den});
    acc_next = carry ? (sum - {1'b0, eff_den}) : sum;
    p_next   = {1'b0, eff_int} + {{CNT_W{1'b0}}, carry};

    cnt_next  = boundary ? '0 : (cnt + 1'b1);
    half_next = boundary ? (p_next >> 1) : (cur_period >> 1);
    r_p_next  = ({1'b0, cnt_next} < half_next);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q         <= 1'b0;
      running      <= 1'b0;
      cnt          <= '0;
      acc          <= '0;
      odd          <= 1'b0;
      r_p          <= 1'b0;
      period_start <= 1'b0;
      cur_period   <= '0;
      cfg_err      <= 1'b0;
      act_int      <= CNT_W'(INT_DEF);
      act_num      <= FRAC_W'(NUM_DEF);
      act_den      <= FRAC_W'(DEN_DEF);
      pend_vld     <= 1'b0;
      pend_int     <= '0;
      pend_num     <= '0;
      pend_den     <= '0;
    end else begin
      en_q <= en;

      if (boundary && pend_vld) begin
        act_int  <= pend_int;
        act_num  <= pend_num;
        act_den  <= pend_den;
        pend_vld <= 1'b0;
      end
      // Written after the consume above so a load coinciding with a boundary
      // stays pending for the following boundary.
      if (cfg_ok) begin
        pend_int <= cfg_int;
        pend_num <= cfg_num;
        pend_den <= cfg_den;
        pend_vld <= 1'b1;
      end
      if (cfg_load) begin
        cfg_err <= !cfg_ok;
      end

      if (boundary) begin
        running      <= 1'b1;
        acc          <= acc_next;
        cur_period   <= p_next;
        cnt          <= '0;
        odd          <= p_next[0];
        r_p          <= r_p_next;
        period_start <= 1'b1;
      end else if (go_idle) begin
        running      <= 1'b0;
        cnt          <= '0;
        r_p          <= 1'b0;
        period_start <= 1'b0;
      end else begin
        period_start <= 1'b0;
        if (running) begin
          cnt <= cnt_next;
          r_p <= r_p_next;
        end else begin
          r_p <= 1'b0;
        end
      end
    end
  end

  // Half-cycle extension for odd periods: r_n trails r_p by half a cycle.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_n <= 1'b0;
    end else begin
      r_n <= r_p;
    end
  end

  // odd only changes at a boundary, where r_p was 0 for the whole last cycle
  // so r_n is 0 as well; the mux select never switches under a high input.
  assign div_clk = r_p | (odd & r_n);

endmodule

// File: tb/tb_frac_clk_div.sv
// tb/tb_frac_clk_div.sv - directed self-checking bench for frac_clk_div

module tb_frac_clk_div;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [7:0] cfg_int;
  logic [7:0] cfg_num;
  logic [7:0] cfg_den;
  logic       cfg_load;
  logic       div_clk;
  logic       period_start;
  logic [8:0] cur_period;
  logic       cfg_err;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_def[10] = '{8, 9, 9, 8, 9, 9, 8, 9, 9, 9};

  frac_clk_div dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .cfg_int      (cfg_int),
    .cfg_num      (cfg_num),
    .cfg_den      (cfg_den),
    .cfg_load     (cfg_load),
    .div_clk      (div_clk),
    .period_start (period_start),
    .cur_period   (cur_period),
    .cfg_err      (cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load_cfg(input int ni, input int nn, input int nd);
    cfg_int  = 8'(ni);
    cfg_num  = 8'(nn);
    cfg_den  = 8'(nd);
    cfg_load = 1'b1;
    tick();
    cfg_load = 1'b0;
  endtask

  task automatic wait_start(output bit ok, output int cycles);
    ok = 1'b0;
    cycles = 0;
    for (int i = 0; i < 400; i++) begin
      tick();
      cycles++;
      if (period_start) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Called in a period_start cycle; returns in the next period_start cycle.
  task automatic measure(output int len, output int hi, output int plen);
    plen = int'(cur_period);
    len  = 0;
    hi   = 0;
    do begin
      if (div_clk) hi++;
      @(negedge clk);
      #1;
      if (div_clk) hi++;
      tick();
      len++;
    end while (!period_start && len < 600);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; en = 1'b0; cfg_load = 1'b0;
    cfg_int = '0; cfg_num = '0; cfg_den = '0;
    repeat (3) tick();
    n_checks++;
    if (div_clk !== 1'b0 || period_start !== 1'b0 || cur_period !== 9'd0 || cfg_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: div_clk=%b period_start=%b cur_period=%0d cfg_err=%b expected 0 0 0 0",
               div_clk, period_start, cur_period, cfg_err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (div_clk !== 1'b0 || period_start !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_no_en: div_clk=%b period_start=%b expected 0 0", div_clk, period_start);
    end
  endtask

  task automatic check_default_run(input string tag);
    int len, hi, plen, total;
    total = 0;
    for (int i = 0; i < 10; i++) begin
      measure(len, hi, plen);
      total += len;
      n_checks++;
      if (plen != exp_def[i] || len != exp_def[i] || hi != exp_def[i]) begin
        n_fail++;
        $display("FAIL %s_p%0d: cur_period=%0d len=%0d hi_halves=%0d expected %0d each",
                 tag, i, plen, len, hi, exp_def[i]);
      end
    end
    n_checks++;
    if (total != 87) begin
      n_fail++;
      $display("FAIL %s_total: %0d cycles over 10 periods expected 87", tag, total);
    end
  endtask

  task automatic test_default;
    en = 1'b1;
    tick();
    n_checks++;
    if (div_clk !== 1'b0) begin
      n_fail++;
      $display("FAIL first_rise_early: div_clk=%b expected 0", div_clk);
    end
    tick();
    n_checks++;
    if (div_clk !== 1'b1 || period_start !== 1'b1) begin
      n_fail++;
      $display("FAIL first_rise: div_clk=%b period_start=%b expected 1 1", div_clk, period_start);
    end
    check_default_run("default");
  endtask

  task automatic test_square;
    bit ok;
    int cyc, len, hi, plen;
    load_cfg(4, 0, 1);
    n_checks++;
    if (cfg_err !== 1'b0) begin
      n_fail++;
      $display("FAIL square_cfg_err: cfg_err=%b expected 0", cfg_err);
    end
    wait_start(ok, cyc);
    n_checks++;
    if (!ok || cyc != 7) begin
      n_fail++;
      $display("FAIL square_apply: found=%0d after %0d cycles expected 1 after 7", ok, cyc);
    end
    for (int i = 0; i < 3; i++) begin
      measure(len, hi, plen);
      n_checks++;
      if (plen != 4 || len != 4 || hi != 4) begin
        n_fail++;
        $display("FAIL square_p%0d: cur_period=%0d len=%0d hi_halves=%0d expected 4 4 4", i, plen, len, hi);
      end
    end
  endtask

  task automatic test_alt;
    bit ok;
    int cyc, len, hi, plen;
    int exp_p[4] = '{3, 4, 3, 4};
    load_cfg(3, 1, 2);
    wait_start(ok, cyc);
    for (int i = 0; i < 4; i++) begin
      measure(len, hi, plen);
      n_checks++;
      if (!ok || plen != exp_p[i] || len != exp_p[i] || hi != exp_p[i]) begin
        n_fail++;
        $display("FAIL alt_p%0d: cur_period=%0d len=%0d hi_halves=%0d expected %0d each",
                 i, plen, len, hi, exp_p[i]);
      end
    end
  endtask

  task automatic test_invalid;
    bit ok;
    int cyc, len, hi, plen;
    int exp_p[2] = '{4, 3};
    load_cfg(6, 5, 5);
    n_checks++;
    if (cfg_err !== 1'b1) begin
      n_fail++;
      $display("FAIL bad_num_den: cfg_err=%b expected 1", cfg_err);
    end
    load_cfg(1, 0, 1);
    n_checks++;
    if (cfg_err !== 1'b1) begin
      n_fail++;
      $display("FAIL bad_int: cfg_err=%b expected 1", cfg_err);
    end
    wait_start(ok, cyc);
    for (int i = 0; i < 2; i++) begin
      measure(len, hi, plen);
      n_checks++;
      if (!ok || plen != exp_p[i] || len != exp_p[i]) begin
        n_fail++;
        $display("FAIL keep_cfg_p%0d: cur_period=%0d len=%0d expected %0d", i, plen, len, exp_p[i]);
      end
    end
    load_cfg(5, 0, 1);
    n_checks++;
    if (cfg_err !== 1'b0) begin
      n_fail++;
      $display("FAIL err_clear: cfg_err=%b expected 0", cfg_err);
    end
    wait_start(ok, cyc);
    measure(len, hi, plen);
    n_checks++;
    if (!ok || plen != 5 || len != 5 || hi != 5) begin
      n_fail++;
      $display("FAIL odd5: cur_period=%0d len=%0d hi_halves=%0d expected 5 5 5", plen, len, hi);
    end
  endtask

  task automatic test_load_at_boundary;
    bit ok;
    int cyc, len, hi, plen;
    repeat (4) tick();
    load_cfg(6, 0, 1);
    n_checks++;
    if (period_start !== 1'b1 || cur_period !== 9'd5) begin
      n_fail++;
      $display("FAIL load_at_boundary: period_start=%b cur_period=%0d expected 1 5", period_start, cur_period);
    end
    measure(len, hi, plen);
    n_checks++;
    if (len != 5 || cur_period !== 9'd6) begin
      n_fail++;
      $display("FAIL load_next_boundary: len=%0d next cur_period=%0d expected 5 6", len, cur_period);
    end
    load_cfg(7, 0, 1);
    load_cfg(4, 0, 1);
    load_cfg(9, 9, 9);
    wait_start(ok, cyc);
    n_checks++;
    if (!ok || cfg_err !== 1'b1 || cur_period !== 9'd4) begin
      n_fail++;
      $display("FAIL last_valid_wins: found=%0d cfg_err=%b cur_period=%0d expected 1 1 4", ok, cfg_err, cur_period);
    end
  endtask

  task automatic test_enable;
    bit ok;
    int cyc, len, hi, plen, bad;
    load_cfg(8, 7, 10);
    wait_start(ok, cyc);
    measure(len, hi, plen);
    n_checks++;
    if (!ok || plen != 8 || len != 8 || cur_period !== 9'd9) begin
      n_fail++;
      $display("FAIL en_setup: cur_period=%0d len=%0d next=%0d expected 8 8 9", plen, len, cur_period);
    end
    hi = 0;
    bad = 0;
    for (int c = 0; c < 9; c++) begin
      if (c == 2) en = 1'b0;
      if (div_clk) hi++;
      if (c > 0 && period_start) bad++;
      @(negedge clk);
      #1;
      if (div_clk) hi++;
      tick();
    end
    n_checks++;
    if (hi != 9 || bad != 0) begin
      n_fail++;
      $display("FAIL en_drain: hi_halves=%0d early_starts=%0d expected 9 0", hi, bad);
    end
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      if (div_clk || period_start) bad++;
      @(negedge clk);
      #1;
      if (div_clk) bad++;
      tick();
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL en_idle: %0d active samples while idle expected 0", bad);
    end
    en = 1'b1;
    tick();
    n_checks++;
    if (div_clk !== 1'b0) begin
      n_fail++;
      $display("FAIL reen_early: div_clk=%b expected 0", div_clk);
    end
    tick();
    n_checks++;
    if (div_clk !== 1'b1 || period_start !== 1'b1 || cur_period !== 9'd9) begin
      n_fail++;
      $display("FAIL reen_rise: div_clk=%b period_start=%b cur_period=%0d expected 1 1 9",
               div_clk, period_start, cur_period);
    end
    measure(len, hi, plen);
    n_checks++;
    if (len != 9 || cur_period !== 9'd8) begin
      n_fail++;
      $display("FAIL reen_seq: len=%0d next cur_period=%0d expected 9 8", len, cur_period);
    end
  endtask

  task automatic test_reset_mid;
    load_cfg(6, 5, 5);
    n_checks++;
    if (cfg_err !== 1'b1 || div_clk !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset: cfg_err=%b div_clk=%b expected 1 1", cfg_err, div_clk);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (div_clk !== 1'b0 || cur_period !== 9'd0 || cfg_err !== 1'b0 || period_start !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: div_clk=%b cur_period=%0d cfg_err=%b period_start=%b expected 0 0 0 0",
               div_clk, cur_period, cfg_err, period_start);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tick();
    n_checks++;
    if (period_start !== 1'b1 || cur_period !== 9'd8) begin
      n_fail++;
      $display("FAIL restart: period_start=%b cur_period=%0d expected 1 8", period_start, cur_period);
    end
    check_default_run("restart");
  endtask

  initial begin
    test_reset();
    test_default();
    test_square();
    test_alt();
    test_invalid();
    test_load_at_boundary();
    test_enable();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
